// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential divider and the opcode decoder.
package alu_pkg;

  // Default operand/result width of the ALU datapath
  localparam int unsigned DEF_WIDTH = 8;

  // Divider control states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  // Quotient reported for a zero divisor (all ones at the default width)
  localparam logic [DEF_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtractor, built as an adder with the
// subtrahend inverted and carry-in forced to one.
module trial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] difference,
  output logic           neg
);

  logic [WIDTH:0] cin_one;

  // Two's-complement subtract; MSB of the result is the borrow/sign
  always_comb begin
    cin_one    = '0;
    cin_one[0] = 1'b1;
    difference = minuend + ~subtrahend + cin_one;
    neg        = difference[WIDTH];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// WIDTH iterations per operation, divide-by-zero answered in one edge.
module seq_div
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e     state;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] prem;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dvsr;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH:0]   next_prem;
  logic [WIDTH-1:0] next_q;

  // The partial remainder stays below the divisor, so its top bit is always
  // zero and drops out of the left shift; the cast keeps the full shift
  // expression visible.
  assign shifted = (WIDTH+1)'({prem, qreg[WIDTH-1]});

  trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .minuend    (shifted),
    .subtrahend ({1'b0, dvsr}),
    .difference (trial),
    .neg        (trial_neg)
  );

  // Restore on a negative trial, otherwise keep the difference and set a 1
  always_comb begin
    next_prem = trial_neg ? shifted : trial;
    next_q    = {qreg[WIDTH-2:0], ~trial_neg};
  end

  // Control FSM and datapath registers with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prem        <= '0;
      qreg        <= '0;
      dvsr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op2 == '0) begin
              done        <= 1'b1;
              quot        <= '1;
              rem         <= op1;
              div_by_zero <= 1'b1;
            end else begin
              qreg        <= op1;
              dvsr        <= op2;
              prem        <= '0;
              cnt         <= '0;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          prem <= next_prem;
          qreg <= next_q;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            quot  <= next_q;
            rem   <= next_prem[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: the driver pushes reference results when an
// operation is accepted, the monitor pops and compares on every done pulse.
module tb_seq_div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op1 = '0;
  logic [7:0] op2 = '0;
  logic       busy;
  logic       done;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       div_by_zero;

  seq_div #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op1         (op1),
    .op2         (op2),
    .busy        (busy),
    .done        (done),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned z;
    int unsigned lat;
    int unsigned n0;
  } exp_t;

  exp_t sc[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: plain integer division with the zero-divisor rule
  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned n);
    exp_t e;
    e.n0 = n;
    if (b == 0) begin
      e.q = 255; e.r = a; e.z = 1; e.lat = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 0; e.lat = 8;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sc.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sc.pop_front();
        check("quot", quot, e.q);
        check("rem", rem, e.r);
        check("div_by_zero", div_by_zero, e.z);
        check("latency", edge_n - (e.n0 + 1), e.lat);
      end
    end
  end

  // Called at a negedge with the FSM idle; returns at the negedge after the sampling edge
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    op1   = a;
    op2   = b;
    sc.push_back(model(a, b, edge_n));
    @(negedge clk);
    start = 1'b0;
    op1   = 8'($urandom);
    op2   = 8'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("done_seen", done, 1);
  endtask

  initial begin
    int seen;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic op with busy profile
    start_op(8'd200, 8'd7);
    for (int i = 0; i < 8; i++) begin
      check("busy_run", busy, 1);
      @(negedge clk);
    end
    check("done_at_8", done, 1);
    check("busy_end", busy, 0);

    // Back-to-back chain
    @(negedge clk);
    start_op(8'd255, 8'd1);
    wait_done();
    start_op(8'd5, 8'd9);
    wait_done();
    start_op(8'd0, 8'd3);
    wait_done();

    // Divide by zero
    @(negedge clk);
    start_op(8'd123, 8'd0);
    check("dbz_done_next", done, 1);
    check("dbz_busy", busy, 0);
    @(negedge clk);
    check("dbz_busy_after", busy, 0);
    check("dbz_done_pulse", done, 0);

    // Start held at done, then an ignored start mid-operation
    start_op(8'd100, 8'd10);
    wait_done();
    start_op(8'd81, 8'd9);
    repeat (3) @(negedge clk);
    check("busy_at_ignore", busy, 1);
    start = 1'b1; op1 = 8'd50; op2 = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Asynchronous reset after three iterations
    @(negedge clk);
    start_op(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quot", quot, 0);
    check("abort_rem", rem, 0);
    check("abort_dbz", div_by_zero, 0);
    sc.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    start_op(8'd200, 8'd7);
    wait_done();

    // Corner pairs followed by a biased random sweep, all back-to-back
    begin
      logic [7:0] ca [7];
      logic [7:0] cb [7];
      ca = '{8'd0, 8'd255, 8'd255, 8'd254, 8'd128, 8'd1, 8'd255};
      cb = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd1, 8'd128, 8'd128};
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
        start_op(ca[i], cb[i]);
        wait_done();
      end
    end
    for (int i = 0; i < 2500; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      int unsigned sel;
      a   = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 8'd0;
      else if (sel == 1) b = 8'd1;
      else if (sel == 2) b = 8'd255;
      else if (sel < 5) b = 8'($urandom_range(1, 15));
      else b = 8'($urandom_range(0, 255));
      start_op(a, b);
      wait_done();
    end

    // Drain outstanding expectations
    @(negedge clk);
    for (int i = 0; i < 20 && sc.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
